// File: rtl/vertex_stim_gen.sv
// On-chip vertex stimulus source: fills a payload register word by word from
// xorshift32, a ramp, or zeros, then presents it over a valid/ready handshake.
module vertex_stim_gen #(
  parameter int unsigned N_VERT    = 3,
  parameter int unsigned XWIDTH    = 17,
  parameter int unsigned YWIDTH    = 17,
  parameter int unsigned ZWIDTH    = 29,
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       start_in,
  input  logic [1:0]                 mode_in,
  input  logic [CNT_WIDTH-1:0]       num_in,
  input  logic                       stop_in,
  input  logic                       ready_in,
  output logic                       valid_out,
  output logic [N_VERT*XWIDTH-1:0]   x,
  output logic [N_VERT*YWIDTH-1:0]   y,
  output logic [N_VERT*ZWIDTH-1:0]   z,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [CNT_WIDTH-1:0]       sent_count_out
);

  localparam int unsigned TOTAL = N_VERT * (XWIDTH + YWIDTH + ZWIDTH);
  localparam int unsigned WORDS = (TOTAL + 31) / 32;
  localparam int unsigned KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned Y_OFF = N_VERT * XWIDTH;
  localparam int unsigned Z_OFF = N_VERT * (XWIDTH + YWIDTH);
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [TOTAL-1:0] WMASK = TOTAL'(64'h0000_0000_FFFF_FFFF);

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} state_t;

  state_t               state;
  logic [TOTAL-1:0]     s_q;
  logic [TOTAL-1:0]     s_rand;
  logic [TOTAL-1:0]     s_ramp;
  logic [TOTAL-1:0]     lane_mask;
  logic [31:0]          rng_q;
  logic [31:0]          rng_nx;
  logic [KW-1:0]        k_q;
  logic [1:0]           mode_q;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 stop_pend;

  function automatic logic [31:0] xs_step(input logic [31:0] r);
    logic [31:0] t;
    t = r ^ (r << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Random fill writes the fresh word into 32-bit lane k, upper lane truncated.
  always_comb begin
    rng_nx    = xs_step(rng_q);
    lane_mask = WMASK << {k_q, 5'b0};
    s_rand    = (s_q & ~lane_mask) | (TOTAL'({WORDS{rng_nx}}) & lane_mask);
    cnt_nx    = sent_count_out + CNT_WIDTH'(1);
  end

  for (genvar i = 0; i < N_VERT; i++) begin : g_ramp
    assign s_ramp[i*XWIDTH +: XWIDTH]         = XWIDTH'(sent_count_out);
    assign s_ramp[Y_OFF + i*YWIDTH +: YWIDTH] = YWIDTH'(sent_count_out);
    assign s_ramp[Z_OFF + i*ZWIDTH +: ZWIDTH] = ZWIDTH'(sent_count_out);
  end

  assign x = s_q[0 +: N_VERT*XWIDTH];
  assign y = s_q[Y_OFF +: N_VERT*YWIDTH];
  assign z = s_q[Z_OFF +: N_VERT*ZWIDTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      rng_q          <= SEED_EFF;
      s_q            <= '0;
      k_q            <= '0;
      mode_q         <= '0;
      num_q          <= '0;
      stop_pend      <= 1'b0;
      valid_out      <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      sent_count_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            mode_q         <= mode_in;
            num_q          <= num_in;
            rng_q          <= SEED_EFF;
            sent_count_out <= '0;
            k_q            <= '0;
            stop_pend      <= 1'b0;
            busy_out       <= 1'b1;
            state          <= FILL;
          end
        end
        FILL: begin
          stop_pend <= stop_pend | stop_in;
          case (mode_q)
            2'd1:    s_q <= s_ramp;
            2'd2:    s_q <= '0;
            default: begin
              rng_q <= rng_nx;
              s_q   <= s_rand;
            end
          endcase
          if (k_q == KW'(WORDS - 1)) begin
            valid_out <= 1'b1;
            state     <= PRESENT;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        PRESENT: begin
          stop_pend <= stop_pend | stop_in;
          if (ready_in) begin
            sent_count_out <= cnt_nx;
            valid_out      <= 1'b0;
            k_q            <= '0;
            // A stop arriving with the final handshake still ends the run.
            if (((num_q != '0) && (cnt_nx == num_q)) || stop_pend || stop_in) begin
              done_out <= 1'b1;
              state    <= DONE;
            end else begin
              state <= FILL;
            end
          end
        end
        DONE: begin
          done_out <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vertex_stim_gen.sv
// Scoreboard bench for vertex_stim_gen: a high-level model pushes expected
// vertex sets per run; a monitor pops and compares on every handshake.
module tb_vertex_stim_gen;

  localparam int NV = 3, XW = 17, YW = 17, ZW = 29, CW = 16;
  localparam int TOTAL = NV * (XW + YW + ZW);
  localparam int WORDS = (TOTAL + 31) / 32;

  logic              clk_in = 1'b0;
  logic              rst_in, start_in, stop_in, ready_in;
  logic [1:0]        mode_in;
  logic [CW-1:0]     num_in;
  logic              valid_out, busy_out, done_out;
  logic [NV*XW-1:0]  x;
  logic [NV*YW-1:0]  y;
  logic [NV*ZW-1:0]  z;
  logic [CW-1:0]     sent_count_out;

  vertex_stim_gen dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .mode_in(mode_in),
    .num_in(num_in), .stop_in(stop_in), .ready_in(ready_in),
    .valid_out(valid_out), .x(x), .y(y), .z(z), .busy_out(busy_out),
    .done_out(done_out), .sent_count_out(sent_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NV*XW-1:0] x;
    logic [NV*YW-1:0] y;
    logic [NV*ZW-1:0] z;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   hs_count = 0, done_cnt = 0, last_hs = -10, first_vld_cyc = -1;
  logic [XW-1:0] first_x0;
  logic ready_hold = 1'b1, ready_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [NV*XW-1:0] px;
  logic [NV*YW-1:0] py;
  logic [NV*ZW-1:0] pz;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    #1;
    ready_in = ready_rand ? 1'($urandom_range(0, 1)) : ready_hold;
  end

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] r);
    logic [31:0] t;
    t = r ^ (r << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  // Model: per run, the rng restarts at the seed and advances 32 bits per fill word.
  function automatic void push_run(input logic [1:0] m, input int cnt);
    logic [31:0] r;
    logic [WORDS*32-1:0] bits;
    exp_t e;
    r = 32'd1;
    for (int t = 0; t < cnt; t++) begin
      if (m == 2'd1) begin
        for (int i = 0; i < NV; i++) begin
          e.x[i*XW +: XW] = XW'(CW'(t));
          e.y[i*YW +: YW] = YW'(CW'(t));
          e.z[i*ZW +: ZW] = ZW'(CW'(t));
        end
      end else if (m == 2'd2) begin
        e.x = '0; e.y = '0; e.z = '0;
      end else begin
        for (int w = 0; w < WORDS; w++) begin
          r = xs(r);
          bits[w*32 +: 32] = r;
        end
        e.x = bits[0 +: NV*XW];
        e.y = bits[NV*XW +: NV*YW];
        e.z = bits[NV*(XW+YW) +: NV*ZW];
      end
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk_in) begin
    if (prev_stall) begin
      chk("stall_valid", 128'(valid_out), 128'(1'b1));
      chk("stall_x", 128'(x), 128'(px));
      chk("stall_y", 128'(y), 128'(py));
      chk("stall_z", 128'(z), 128'(pz));
    end
    prev_stall = valid_out && !ready_in && !rst_in;
    px = x; py = y; pz = z;
    if (valid_out === 1'b1 && first_vld_cyc < 0) begin
      first_vld_cyc = cyc;
      first_x0 = x[XW-1:0];
    end
    if (valid_out === 1'b1 && ready_in === 1'b1 && rst_in === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", 128'(hs_count), 128'(-1));
      end else begin
        e_mon = exp_q.pop_front();
        chk("payload_x", 128'(x), 128'(e_mon.x));
        chk("payload_y", 128'(y), 128'(e_mon.y));
        chk("payload_z", 128'(z), 128'(e_mon.z));
      end
      hs_count++;
      last_hs = cyc;
    end
    if (done_out === 1'b1) begin
      done_cnt++;
      chk("done_after_hs", 128'(cyc), 128'(last_hs + 1));
      chk("done_valid_low", 128'(valid_out), 128'(1'b0));
    end
  end

  task automatic do_run(input logic [1:0] m, input logic [CW-1:0] n, input int exp_cnt,
                        input int stop_after, input bit poke);
    int d0, h0, st;
    d0 = done_cnt;
    h0 = hs_count;
    push_run(m, exp_cnt);
    first_vld_cyc = -1;
    @(posedge clk_in); #1;
    mode_in = m; num_in = n; start_in = 1'b1; st = cyc;
    @(posedge clk_in); #1;
    start_in = 1'b0; mode_in = ~m; num_in = n + CW'(5);
    if (poke) begin
      repeat (2) @(posedge clk_in);
      #1 start_in = 1'b1; mode_in = 2'd0; num_in = CW'(1);
      chk("busy_during_poke", 128'(busy_out), 128'(1'b1));
      @(posedge clk_in); #1 start_in = 1'b0;
    end
    if (stop_after >= 0) begin
      for (int i = 0; i < 500 && (hs_count - h0) < stop_after; i++) @(negedge clk_in);
      @(posedge clk_in); #1 stop_in = 1'b1;
      @(posedge clk_in); #1 stop_in = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk_in);
    chk("done_seen", 128'(done_cnt != d0), 128'(1'b1));
    repeat (3) @(negedge clk_in);
    chk("done_once", 128'(done_cnt - d0), 128'(1));
    chk("sent_count", 128'(sent_count_out), 128'(CW'(exp_cnt)));
    chk("handshakes", 128'(hs_count - h0), 128'(exp_cnt));
    chk("busy_after", 128'(busy_out), 128'(1'b0));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    chk("latency", 128'(first_vld_cyc - st), 128'(WORDS + 1));
    exp_q.delete();
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; stop_in = 1'b0; mode_in = '0; num_in = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_valid", 128'(valid_out), 128'(1'b0));
    chk("rst_busy", 128'(busy_out), 128'(1'b0));
    chk("rst_done", 128'(done_out), 128'(1'b0));
    chk("rst_count", 128'(sent_count_out), 128'(0));
    chk("rst_payload", 128'({x, y, z} != '0), 128'(1'b0));

    // Single random set with the default seed.
    do_run(2'd0, CW'(1), 1, -1, 0);
    chk("first_x0", 128'(first_x0), 128'(17'h02021));

    // Ramp run.
    do_run(2'd1, CW'(3), 3, -1, 0);

    // Stalled random run, twice for reproducibility.
    for (int rep = 0; rep < 2; rep++) begin
      ready_hold = 1'b0;
      fork
        do_run(2'd0, CW'(2), 2, -1, 0);
        begin
          for (int i = 0; i < 100 && valid_out !== 1'b1; i++) @(negedge clk_in);
          repeat (5) @(posedge clk_in);
          ready_hold = 1'b1;
        end
      join
    end

    // Unbounded zero run stopped during the third fill.
    do_run(2'd2, CW'(0), 3, 2, 0);

    // Reset while a set is presented.
    begin
      int d0, h0;
      d0 = done_cnt;
      h0 = hs_count;
      push_run(2'd0, 1);
      @(posedge clk_in); #1 mode_in = 2'd0; num_in = '0; start_in = 1'b1;
      @(posedge clk_in); #1 start_in = 1'b0;
      for (int i = 0; i < 100 && hs_count == h0; i++) @(negedge clk_in);
      ready_hold = 1'b0;
      for (int i = 0; i < 100 && !(valid_out === 1'b1 && ready_in === 1'b0); i++) @(negedge clk_in);
      chk("pre_rst_count", 128'(sent_count_out), 128'(1));
      @(posedge clk_in); #1 rst_in = 1'b1;
      @(posedge clk_in); #1 rst_in = 1'b0;
      @(negedge clk_in);
      chk("midrst_valid", 128'(valid_out), 128'(1'b0));
      chk("midrst_busy", 128'(busy_out), 128'(1'b0));
      chk("midrst_count", 128'(sent_count_out), 128'(0));
      repeat (3) @(negedge clk_in);
      chk("midrst_no_done", 128'(done_cnt - d0), 128'(0));
      exp_q.delete();
      ready_hold = 1'b1;
    end

    // Start while busy is ignored.
    do_run(2'd1, CW'(3), 3, -1, 1);

    // Start coinciding with reset is ignored.
    @(posedge clk_in); #1 rst_in = 1'b1; start_in = 1'b1; mode_in = 2'd0; num_in = CW'(1);
    @(posedge clk_in); #1 rst_in = 1'b0; start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rststart_busy", 128'(busy_out), 128'(1'b0));
    chk("rststart_valid", 128'(valid_out), 128'(1'b0));
    do_run(2'd0, CW'(1), 1, -1, 0);
    chk("repeat_x0", 128'(first_x0), 128'(17'h02021));

    // Randomized runs with random back-pressure.
    ready_rand = 1'b1;
    for (int r = 0; r < 5; r++) begin
      logic [1:0] m;
      int n;
      m = 2'($urandom_range(0, 3));
      n = $urandom_range(1, 4);
      do_run(m, CW'(n), n, -1, 0);
    end
    ready_rand = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vertex_stim_gen.md
Name: vertex_stim_gen

Overview:
- Parametrised on-chip stimulus source for the rasterizer and other vertex-consuming blocks.
- Supersedes fixed free-running noise registers with:
  - configurable vertex count and coordinate widths
  - a selectable data mode
  - a bounded or unbounded transaction count
  - a valid/ready output handshake
  - start/done control and reproducible seeding
- Sits between board controls and the device under test in hardware bring-up top levels.

Parameters:
- N_VERT, 3, vertices per transaction.
- XWIDTH, 17, width of each x coordinate.
- YWIDTH, 17, width of each y coordinate.
- ZWIDTH, 29, width of each z coordinate.
- CNT_WIDTH, 16, width of num_in and sent_count_out.
- SEED, 32'h0000_0001, xorshift32 seed; value 0 is replaced by 1.
- Derived: TOTAL = N_VERT*(XWIDTH+YWIDTH+ZWIDTH); WORDS = ceil(TOTAL/32). Defaults give TOTAL=189, WORDS=6.

Ports:
- clk_in, input, 1, sole clock.
- rst_in, input, 1, synchronous active-high reset.
- start_in, input, 1, one-cycle pulse; honoured only in IDLE.
- mode_in, input, 2, data mode, sampled at accepted start.
- num_in, input, CNT_WIDTH, transactions to send (0 = unbounded), sampled at accepted start.
- stop_in, input, 1, request to end an unbounded or bounded run early.
- ready_in, input, 1, downstream ready.
- valid_out, output, 1, vertex set valid.
- x, output, N_VERT x XWIDTH, packed x coordinates.
- y, output, N_VERT x YWIDTH, packed y coordinates.
- z, output, N_VERT x ZWIDTH, packed z coordinates.
- busy_out, output, 1, high in any state other than IDLE.
- done_out, output, 1, one-cycle pulse on run completion.
- sent_count_out, output, CNT_WIDTH, handshakes completed in the current or last run.

Behaviour:
- Reset: state=IDLE, rng=SEED (or 1 if SEED is 0), valid_out=0, busy_out=0, done_out=0, sent_count_out=0, payload register S=0. Reset mid-run aborts immediately with no done_out pulse.
- Payload register S[TOTAL-1:0] packing:
  - x[i] = S[i*XWIDTH +: XWIDTH]
  - y[i] = S[N_VERT*XWIDTH + i*YWIDTH +: YWIDTH]
  - z[i] = S[N_VERT*(XWIDTH+YWIDTH) + i*ZWIDTH +: ZWIDTH]
- xorshift32 step: r ^= r<<13; r ^= r>>17; r ^= r<<5. The word produced is the post-step value.
- State machine:
  - IDLE:
    - start_in → latch mode and num, rng = SEED, sent_count_out = 0, go to FILL with word index k = 0.
    - start_in coinciding with rst_in is ignored.
  - FILL: lasts exactly WORDS cycles in every mode. In cycle k:
    - mode 0 or 3 (RANDOM): step rng, write the word to S[32k +: 32], truncated above TOTAL.
    - mode 1 (RAMP): every coordinate = sent_count_out, zero-extended or truncated to its width.
    - mode 2 (ZERO): S = 0.
    - After k = WORDS-1, go to PRESENT.
  - PRESENT:
    - valid_out=1; S is held stable while ready_in=0.
    - On valid_out && ready_in: sent_count_out += 1.
    - If the new count equals num (num≠0) or stop is pending → DONE; otherwise → FILL.
  - DONE: one cycle, done_out=1, valid_out=0, then IDLE.
- stop_in:
  - In FILL: latched as pending; the set being filled is still presented and completed.
  - In PRESENT: the current handshake still completes; the transition is then to DONE.
  - In IDLE or DONE: ignored.
- Latency:
  - start accepted at cycle t → valid_out first high at t+1+WORDS.
  - Back-to-back throughput: one transaction per WORDS+1 cycles when ready_in is held high.
- sent_count_out wraps modulo 2^CNT_WIDTH in unbounded runs. It holds its value after DONE until the next accepted start.
- valid_out never falls without a handshake except on rst_in.

Test Plan:
- Reset, then start_in with mode 0, num 1, SEED 1, ready_in high → valid_out rises 7 cycles after start; x[0]=17'h02021; done_out pulses the cycle after the handshake; sent_count_out=1.
- mode 1, num 3, ready_in high → three transactions with all coordinates equal to 0, 1, 2 in turn; done_out pulses once; sent_count_out=3; busy_out low afterward.
- mode 0, num 2, ready_in low for 5 cycles during PRESENT → x, y, z stable across the stall; exactly 2 handshakes; rerunning with the same start sequence reproduces identical payloads.
- mode 2, num 0, stop_in pulsed during the third FILL → third set of zeros still presented; done_out pulses after its handshake; sent_count_out=3.
- rst_in asserted mid-PRESENT while valid_out=1 → next cycle valid_out=0, busy_out=0, sent_count_out=0, no done_out pulse.
- start_in pulsed while busy_out=1, and start_in asserted together with rst_in → both ignored; run count and payload sequence are unaffected.
